// File: rtl/mcp492x_pkg.sv
// Shared encodings for the MCP4921/MCP4922 SPI DAC controller.
// States, frame bit positions, channel ids and the frame builder.
package mcp492x_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    GAP,
    PULSE
  } state_t;

  localparam int FRAME_W  = 16;
  localparam int DATA_W   = 12;
  localparam int BIT_CH   = 15;
  localparam int BIT_BUF  = 14;
  localparam int BIT_GA   = 13;
  localparam int BIT_SHDN = 12;

  localparam logic CH_A = 1'b0;
  localparam logic CH_B = 1'b1;

  function automatic logic [FRAME_W-1:0] make_frame(
    input logic              ch,
    input logic              vref_buf,
    input logic              gain_one,
    input logic              shdn,
    input logic [DATA_W-1:0] data
  );
    logic [FRAME_W-1:0] f;
    f               = '0;
    f[BIT_CH]       = ch;
    f[BIT_BUF]      = vref_buf;
    f[BIT_GA]       = gain_one;
    f[BIT_SHDN]     = ~shdn;
    f[DATA_W-1:0]   = data;
    return f;
  endfunction

endpackage

// File: rtl/spi_tick_div.sv
// Enable generator: tick every `limit` cycles, restartable by clr.
// Ports: clk, rst_n, clr (sync restart), limit (period), tick (pulse).
module spi_tick_div #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic [W-1:0] limit,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = (cnt == limit - W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/mcp492x_dual_dac_ctrl.sv
// SPI master for MCP4921/MCP4922: one buffered sample per channel,
// round-robin 16-bit frames, optional LDAC pulse. Ports: sample
// handshakes (a/b), i_shdn, SPI pins (SPICLK/MOSI/CS/LDAC), o_busy.
module mcp492x_dual_dac_ctrl
  import mcp492x_pkg::*;
#(
  parameter int CLKDIV    = 4,
  parameter int CSGAP     = 2,
  parameter int CHANNELS  = 2,
  parameter bit REFBUFFER = 1'b1,
  parameter bit GAINONE   = 1'b1,
  parameter int LDAC_MODE = 1
) (
  input  logic        CLK,
  input  logic        i_RSTN,
  input  logic [11:0] i_data_a,
  input  logic        i_valid_a,
  output logic        o_ready_a,
  input  logic [11:0] i_data_b,
  input  logic        i_valid_b,
  output logic        o_ready_b,
  input  logic [1:0]  i_shdn,
  output logic        o_SPICLK,
  output logic        o_MOSI,
  output logic        o_CS,
  output logic        o_LDAC,
  output logic        o_busy
);

  localparam int CW = $clog2(CLKDIV * CSGAP) + 1;
  localparam logic [CW-1:0] DIV_LIM = CW'(CLKDIV);
  localparam logic [CW-1:0] GAP_LIM = CW'(CLKDIV * CSGAP);
  localparam bit HAS_B = (CHANNELS == 2);
  localparam bit USE_LDAC = (LDAC_MODE != 0);

  state_t state, nxt;

  logic [1:0]  pend;
  logic [11:0] dat_a, dat_b;
  logic        shdn_a, shdn_b;
  logic        prefer_a;
  logic [15:0] sreg;
  logic        hi_phase;
  logic [3:0]  bit_cnt;
  logic        tick, div_clr, load;
  logic        grant_b;
  logic        acc_a, acc_b;
  logic        clr_a, clr_b;
  logic [CW-1:0] lim;

  assign o_ready_a = ~pend[0];
  assign o_ready_b = HAS_B ? ~pend[1] : 1'b0;
  assign acc_a = i_valid_a & o_ready_a;
  assign acc_b = i_valid_b & o_ready_b;

  // A wins unless B is also waiting and A went last.
  assign grant_b = pend[1] & (~pend[0] | ~prefer_a);
  assign clr_a = load & ~grant_b;
  assign clr_b = load & grant_b;

  assign lim = (state == GAP) ? GAP_LIM : DIV_LIM;
  assign div_clr = (state == IDLE);

  spi_tick_div #(
    .W(CW)
  ) u_div (
    .clk  (CLK),
    .rst_n(i_RSTN),
    .clr  (div_clr),
    .limit(lim),
    .tick (tick)
  );

  always_comb begin
    nxt  = state;
    load = 1'b0;
    unique case (state)
      IDLE: begin
        if (|pend) begin
          nxt  = LOAD;
          load = 1'b1;
        end
      end
      LOAD: begin
        if (tick) nxt = SHIFT;
      end
      SHIFT: begin
        if (tick && !hi_phase && bit_cnt == 4'd15) nxt = GAP;
      end
      GAP: begin
        if (tick) begin
          if (|pend) begin
            nxt  = LOAD;
            load = 1'b1;
          end else if (USE_LDAC) begin
            nxt = PULSE;
          end else begin
            nxt = IDLE;
          end
        end
      end
      PULSE: begin
        if (tick) nxt = IDLE;
      end
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state    <= IDLE;
      pend     <= '0;
      dat_a    <= '0;
      dat_b    <= '0;
      shdn_a   <= 1'b0;
      shdn_b   <= 1'b0;
      prefer_a <= 1'b1;
      sreg     <= '0;
      hi_phase <= 1'b0;
      bit_cnt  <= '0;
    end else begin
      state <= nxt;
      pend  <= {(pend[1] & ~clr_b) | acc_b,
                (pend[0] & ~clr_a) | acc_a};
      if (acc_a) begin
        dat_a  <= i_data_a;
        shdn_a <= i_shdn[0];
      end
      if (acc_b) begin
        dat_b  <= i_data_b;
        shdn_b <= i_shdn[1];
      end
      if (load) begin
        sreg <= grant_b
          ? make_frame(CH_B, REFBUFFER, GAINONE, shdn_b, dat_b)
          : make_frame(CH_A, REFBUFFER, GAINONE, shdn_a, dat_a);
        prefer_a <= grant_b;
        hi_phase <= 1'b0;
        bit_cnt  <= '0;
      end else if (state == LOAD && tick) begin
        hi_phase <= 1'b1;
      end else if (state == SHIFT && tick) begin
        hi_phase <= ~hi_phase;
        // Next bit goes out on the SPICLK falling edge.
        if (hi_phase) begin
          sreg <= {sreg[14:0], 1'b0};
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
        end
      end
    end
  end

  assign o_CS     = ~(state == LOAD || state == SHIFT);
  assign o_SPICLK = (state == SHIFT) & hi_phase;
  assign o_MOSI   = ~o_CS & sreg[15];
  assign o_LDAC   = USE_LDAC ? (state != PULSE) : 1'b0;
  assign o_busy   = (state != IDLE);

endmodule
